// File: rtl/flash_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_key_sched_if
// Purpose  : Command handshake between the key scheduler (master) and the
//            SPI flash command engine (slave).
// Signals  : cmd_req  - command request, scheduler -> engine
//            cmd_id   - index of the granted source, scheduler -> engine
//            cmd_ack  - engine accepted the command, engine -> scheduler
//            cmd_done - one-cycle completion pulse, engine -> scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface flash_key_sched_if #(
    parameter int ID_W = 2
);
    logic            cmd_req;
    logic [ID_W-1:0] cmd_id;
    logic            cmd_ack;
    logic            cmd_done;

    modport master (
        output cmd_req,
        output cmd_id,
        input  cmd_ack,
        input  cmd_done
    );

    modport slave (
        input  cmd_req,
        input  cmd_id,
        output cmd_ack,
        output cmd_done
    );
endinterface
`default_nettype wire

// File: rtl/flash_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : flash_key_sched
// Purpose  : Latches debounced key presses as pending flash operations,
//            grants them one at a time in round-robin order, runs the
//            req/ack/done handshake with the flash engine and abandons an
//            operation that does not complete within TIMEOUT cycles.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            key_pulse - one-cycle press pulses, one bit per source
//            flash     - command handshake (master side)
//            pend      - pending-request vector
//            busy      - an operation is in REQ or WAIT
//            fin       - one-cycle pulse, operation cmd_id completed
//            tmo       - one-cycle pulse, operation cmd_id timed out
//            drop      - one-cycle pulse, a press was coalesced
// Revision : 1.0 - initial release
// ============================================================================
module flash_key_sched #(
    parameter int KEY_W   = 3,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 50_000_000,
    parameter int CNT_W   = 26
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [KEY_W-1:0] key_pulse,
    flash_key_sched_if.master     flash,
    output logic      [KEY_W-1:0] pend,
    output logic                  busy,
    output logic                  fin,
    output logic                  tmo,
    output logic                  drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [ID_W-1:0]  c_LAST_RST = ID_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [KEY_W-1:0] r_pend;
    logic [KEY_W-1:0] w_pend_nxt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_id_nxt;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_fin;
    logic             w_fin_nxt;
    logic             r_tmo;
    logic             w_tmo_nxt;
    logic             r_drop;
    logic             w_drop_nxt;

    logic             w_gnt_vld;
    logic [ID_W-1:0]  w_gnt;
    logic [KEY_W-1:0] w_gnt_oh;
    logic [KEY_W-1:0] w_svc;
    logic             w_take;
    logic             w_expire;

    // ------------------------------------------------------------------
    // Round-robin search: each pending source is ranked by its distance
    // from the slot after r_last; the smallest distance wins.
    // ------------------------------------------------------------------
    always_comb begin
        int best_d;
        int d;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_gnt_oh  = '0;
        best_d    = KEY_W;
        d         = 0;
        for (int j = 0; j < KEY_W; j++) begin
            d = j - int'(r_last) - 1;
            if (d < 0) begin
                d = d + KEY_W;
            end
            if (r_pend[j] && (d < best_d)) begin
                best_d    = d;
                w_gnt_vld = 1'b1;
                w_gnt     = ID_W'(j);
            end
        end
        for (int j = 0; j < KEY_W; j++) begin
            w_gnt_oh[j] = w_gnt_vld && (w_gnt == ID_W'(j));
        end
    end

    // One-hot of the source currently being served (empty in IDLE)
    always_comb begin
        w_svc = '0;
        for (int j = 0; j < KEY_W; j++) begin
            w_svc[j] = (r_state != S_IDLE) && (r_id == ID_W'(j));
        end
    end

    assign w_expire = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_fin_nxt   = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_take      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = S_REQ;
                    w_take      = 1'b1;
                    w_id_nxt    = w_gnt;
                    w_last_nxt  = w_gnt;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Acceptance takes priority over an expiring counter
                if (flash.cmd_ack) begin
                    w_state_nxt = S_WAIT;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (flash.cmd_done) begin
                    w_state_nxt = S_IDLE;
                    w_fin_nxt   = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A press on a source already pending or in service is merged
        // into the existing request; the granted bit is retired here.
        w_drop_nxt = |(key_pulse & (r_pend | w_svc));
        w_pend_nxt = r_pend | (key_pulse & ~r_pend & ~w_svc);
        if (w_take) begin
            w_pend_nxt = w_pend_nxt & ~w_gnt_oh;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_id    <= '0;
            r_last  <= c_LAST_RST;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
            r_tmo   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fin   <= w_fin_nxt;
            r_tmo   <= w_tmo_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Outputs are decoded from registers only
    assign flash.cmd_req = (r_state == S_REQ);
    assign flash.cmd_id  = r_id;
    assign busy          = (r_state != S_IDLE);
    assign pend          = r_pend;
    assign fin           = r_fin;
    assign tmo           = r_tmo;
    assign drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_flash_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_key_sched
// Purpose  : Directed self-checking bench for flash_key_sched (TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_key_sched;

    localparam int c_KEY_W   = 3;
    localparam int c_ID_W    = 2;
    localparam int c_TIMEOUT = 16;
    localparam int c_CNT_W   = 5;

    logic               clk;
    logic               rst;
    logic [c_KEY_W-1:0] key_pulse;
    logic [c_KEY_W-1:0] pend;
    logic               busy;
    logic               fin;
    logic               tmo;
    logic               drop;

    int n_checks;
    int n_errors;

    flash_key_sched_if #(.ID_W(c_ID_W)) u_if ();

    flash_key_sched #(
        .KEY_W   (c_KEY_W),
        .ID_W    (c_ID_W),
        .TIMEOUT (c_TIMEOUT),
        .CNT_W   (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .flash     (u_if),
        .pend      (pend),
        .busy      (busy),
        .fin       (fin),
        .tmo       (tmo),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [c_KEY_W-1:0] k);
        key_pulse = k;
        tick();
        key_pulse = '0;
    endtask

    // Advance until cmd_req is seen, bounded
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!u_if.cmd_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(u_if.cmd_req), 32'd1);
    endtask

    // Serve one operation with immediate ack and done
    task automatic do_op(input string tag, input int exp_id);
        wait_req({tag, "_req"});
        check({tag, "_id"}, 32'(u_if.cmd_id), 32'(exp_id));
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
        check({tag, "_req_low"}, 32'(u_if.cmd_req), 32'd0);
        u_if.cmd_done = 1'b1;
        tick();
        u_if.cmd_done = 1'b0;
        check({tag, "_fin"}, 32'(fin), 32'd1);
        check({tag, "_fin_id"}, 32'(u_if.cmd_id), 32'(exp_id));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int drops;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        key_pulse     = '0;
        u_if.cmd_ack  = 1'b0;
        u_if.cmd_done = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_req", 32'(u_if.cmd_req), 32'd0);
        check("rst_id", 32'(u_if.cmd_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {29'd0, fin, tmo, drop}, 32'd0);
        rst = 1'b0;
        tick();

        // Single press on bit 1
        press(3'b010);
        check("single_pend", 32'(pend), 32'b010);
        check("single_req_early", 32'(u_if.cmd_req), 32'd0);
        tick();
        check("single_req", 32'(u_if.cmd_req), 32'd1);
        check("single_id", 32'(u_if.cmd_id), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_pend_clr", 32'(pend), 32'd0);
        tick();
        check("single_req_hold", 32'(u_if.cmd_req), 32'd1);
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
        check("single_req_drop", 32'(u_if.cmd_req), 32'd0);
        check("single_wait_busy", 32'(busy), 32'd1);
        repeat (6) tick();
        check("single_no_fin", 32'(fin), 32'd0);
        u_if.cmd_done = 1'b1;
        tick();
        u_if.cmd_done = 1'b0;
        check("single_fin", 32'(fin), 32'd1);
        check("single_fin_id", 32'(u_if.cmd_id), 32'd1);
        check("single_busy_end", 32'(busy), 32'd0);
        tick();
        check("single_fin_pulse", 32'(fin), 32'd0);

        // Round-robin: last=1 here, so the 3'b111 burst starts at 2
        press(3'b111);
        check("rr_pend", 32'(pend), 32'b111);
        check("rr_nodrop", 32'(drop), 32'd0);
        do_op("rr_a", 2);
        do_op("rr_b", 0);
        do_op("rr_c", 1);
        check("rr_empty", 32'(pend), 32'd0);
        // Bring last to 2 so the next burst wraps to 0,1,2
        press(3'b100);
        do_op("rr_d", 2);
        press(3'b111);
        do_op("rr_e", 0);
        do_op("rr_f", 1);
        do_op("rr_g", 2);
        check("rr_empty2", 32'(pend), 32'd0);

        // Coalescing during WAIT on id 0
        press(3'b001);
        wait_req("co_req");
        check("co_id", 32'(u_if.cmd_id), 32'd0);
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
        drops = 0;
        press(3'b001);
        drops += int'(drop);
        press(3'b100);
        drops += int'(drop);
        press(3'b100);
        drops += int'(drop);
        press(3'b001);
        drops += int'(drop);
        tick();
        drops += int'(drop);
        check("co_drops", 32'(drops), 32'd3);
        check("co_pend", 32'(pend), 32'b100);
        u_if.cmd_done = 1'b1;
        tick();
        u_if.cmd_done = 1'b0;
        check("co_fin", 32'(fin), 32'd1);
        do_op("co_next", 2);
        repeat (4) tick();
        check("co_no_reserve", 32'(u_if.cmd_req), 32'd0);
        check("co_pend_empty", 32'(pend), 32'd0);

        // Timeout on bit 2
        press(3'b100);
        wait_req("to_req");
        check("to_id", 32'(u_if.cmd_id), 32'd2);
        n = 0;
        while (u_if.cmd_req && n < 40) begin
            tick();
            n++;
        end
        check("to_req_len", 32'(n), 32'd16);
        check("to_tmo", 32'(tmo), 32'd1);
        check("to_tmo_id", 32'(u_if.cmd_id), 32'd2);
        check("to_no_fin", 32'(fin), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        tick();
        check("to_tmo_pulse", 32'(tmo), 32'd0);
        press(3'b100);
        do_op("to_retry", 2);

        // Completion on the last counter value beats the timeout
        press(3'b010);
        wait_req("bd_req");
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
        repeat (14) tick();
        check("bd_still_busy", 32'(busy), 32'd1);
        u_if.cmd_done = 1'b1;
        tick();
        u_if.cmd_done = 1'b0;
        check("bd_fin", 32'(fin), 32'd1);
        check("bd_tmo", 32'(tmo), 32'd0);
        check("bd_id", 32'(u_if.cmd_id), 32'd1);

        // Reset in WAIT with two pending requests
        press(3'b010);
        wait_req("rs_req");
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
        press(3'b101);
        check("rs_pend_pre", 32'(pend), 32'b101);
        rst = 1'b1;
        tick();
        check("rs_pend", 32'(pend), 32'd0);
        check("rs_req", 32'(u_if.cmd_req), 32'd0);
        check("rs_id", 32'(u_if.cmd_id), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_pulses", {29'd0, fin, tmo, drop}, 32'd0);
        rst = 1'b0;
        tick();
        press(3'b110);
        do_op("rs_first", 1);
        do_op("rs_second", 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
